or1k_irq_sched: RTL and testbench



---
 rtl/or1k_irq_sched.sv | 137 +++++++++++++
 tb/tb_or1k_irq_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/or1k_irq_sched.sv
// Interrupt scheduler: picks one pending PIC line, presents it to the CPU as a
// single request with a stable ID, and tracks it as in-service until software
// writes a matching EOI over the SPR bus.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | nothing requested; arbitrate picsr_i every cycle
// ST_REQ   | irq_req_o high, irq_id_o frozen until ack or withdraw
// ST_INSVC | CPU took the exception; waiting for EOI carrying irq_id_o
module or1k_irq_sched #(
    parameter string       OPTION_PRIO    = "FIXED",
    parameter logic [10:0] SPR_ID_OFFSET  = 11'h003,
    parameter logic [10:0] SPR_EOI_OFFSET = 11'h004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] picsr_i,
    output logic        irq_req_o,
    output logic [4:0]  irq_id_o,
    input  logic        irq_ack_i,
    input  logic        spr_access_i,
    input  logic        spr_we_i,
    input  logic [15:0] spr_addr_i,
    input  logic [31:0] spr_dat_i,
    output logic        spr_bus_ack_o,
    output logic [31:0] spr_dat_o
);

    localparam bit RR_MODE = (OPTION_PRIO == "ROUND_ROBIN");

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_INSVC = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_id;
    logic [4:0] w_id_nxt;
    logic [4:0] r_rr_ptr;
    logic [4:0] w_rr_nxt;
    logic       r_err;
    logic       w_err_nxt;

    logic       w_id_rd;
    logic       w_eoi_wr;
    logic       w_eoi_match;
    logic       w_eoi_bad;
    logic       w_win_found;
    logic [4:0] w_win_id;
    logic [4:0] w_idx;

    // Only the low 11 address bits select the register; upper bits and the
    // high EOI data bits carry nothing for this block.
    logic w_unused;
    assign w_unused = &{1'b0, spr_dat_i[31:5], spr_addr_i[15:11]};

    assign w_id_rd     = spr_access_i & ~spr_we_i & (spr_addr_i[10:0] == SPR_ID_OFFSET);
    assign w_eoi_wr    = spr_access_i &  spr_we_i & (spr_addr_i[10:0] == SPR_EOI_OFFSET);
    assign w_eoi_match = w_eoi_wr & (r_state == ST_INSVC) & (spr_dat_i[4:0] == r_id);
    assign w_eoi_bad   = w_eoi_wr & ~w_eoi_match;

    // Arbiter: first set line scanning upward from the start index, wrapping.
    // Fixed priority is the same scan anchored at index 0.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = 5'd0;
        w_idx       = 5'd0;
        for (int k = 0; k < 32; k++) begin
            w_idx = (RR_MODE ? r_rr_ptr : 5'd0) + k[4:0];
            if (!w_win_found && picsr_i[w_idx]) begin
                w_win_found = 1'b1;
                w_win_id    = w_idx;
            end
        end
    end

    // Next-state, ID capture, round-robin pointer and sticky error.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_rr_nxt    = r_rr_ptr;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = ST_REQ;
                    w_id_nxt    = w_win_id;
                end
            end
            ST_REQ: begin
                // Ack takes precedence over a line withdrawn in the same cycle.
                if (irq_ack_i)
                    w_state_nxt = ST_INSVC;
                else if (!picsr_i[r_id])
                    w_state_nxt = ST_IDLE;
            end
            ST_INSVC: begin
                if (w_eoi_match) begin
                    w_state_nxt = ST_IDLE;
                    if (RR_MODE)
                        w_rr_nxt = r_id + 5'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A status read clears err, but a bad EOI in the same cycle sets it.
        if (w_eoi_match || w_id_rd)
            w_err_nxt = 1'b0;
        if (w_eoi_bad)
            w_err_nxt = 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_id     <= 5'd0;
            r_rr_ptr <= 5'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_id     <= w_id_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign irq_req_o     = (r_state == ST_REQ);
    assign irq_id_o      = r_id;
    assign spr_bus_ack_o = spr_access_i;
    assign spr_dat_o     = w_id_rd ? {(r_state == ST_INSVC), r_err, (r_state == ST_REQ),
                                      16'd0, r_rr_ptr, 3'd0, r_id}
                                   : 32'd0;

endmodule

// File: tb/tb_or1k_irq_sched.sv
// Directed bench for or1k_irq_sched: one FIXED and one ROUND_ROBIN instance
// share all inputs; each step checks the instance whose behaviour it targets.
module tb_or1k_irq_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] picsr;
    logic        ack;
    logic        access;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdat;

    logic        f_req, r_req;
    logic [4:0]  f_id, r_id;
    logic        f_bus_ack, r_bus_ack;
    logic [31:0] f_dat, r_dat;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    or1k_irq_sched #(.OPTION_PRIO("FIXED")) dut_fx (
        .clk(clk), .rst(rst), .picsr_i(picsr),
        .irq_req_o(f_req), .irq_id_o(f_id), .irq_ack_i(ack),
        .spr_access_i(access), .spr_we_i(we), .spr_addr_i(addr), .spr_dat_i(wdat),
        .spr_bus_ack_o(f_bus_ack), .spr_dat_o(f_dat)
    );

    or1k_irq_sched #(.OPTION_PRIO("ROUND_ROBIN")) dut_rr (
        .clk(clk), .rst(rst), .picsr_i(picsr),
        .irq_req_o(r_req), .irq_id_o(r_id), .irq_ack_i(ack),
        .spr_access_i(access), .spr_we_i(we), .spr_addr_i(addr), .spr_dat_i(wdat),
        .spr_bus_ack_o(r_bus_ack), .spr_dat_o(r_dat)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_on(input logic [15:0] a);
        access = 1'b1; we = 1'b0; addr = a;
        #1;
    endtask

    task automatic bus_off;
        access = 1'b0; we = 1'b0; addr = 16'h0; wdat = 32'h0;
    endtask

    task automatic eoi(input logic [31:0] d);
        access = 1'b1; we = 1'b1; addr = 16'h0004; wdat = d;
        tick;
        bus_off;
    endtask

    task automatic ack_pulse;
        ack = 1'b1;
        tick;
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; picsr = 32'h0; ack = 1'b0;
        bus_off;
        tick; tick;
        rst = 1'b0;

        // Reset state
        chk("rst_req", {31'd0, f_req}, 32'd0);
        chk("rst_id", {27'd0, f_id}, 32'd0);
        rd_on(16'h0003);
        chk("rst_idreg", f_dat, 32'h0);
        chk("bus_ack", {31'd0, f_bus_ack}, 32'd1);
        bus_off;

        // 1: fixed priority, ack, EOI, re-arbitration
        picsr = 32'h0000_0028;
        tick;
        chk("t1_req", {31'd0, f_req}, 32'd1);
        chk("t1_id", {27'd0, f_id}, 32'd3);
        ack_pulse;
        chk("t1_req_after_ack", {31'd0, f_req}, 32'd0);
        rd_on(16'h0803);
        chk("t1_idreg_insvc", f_dat, 32'h8000_0003);
        tick;
        bus_off;
        picsr = 32'h0000_0020;
        eoi(32'h3);
        chk("t1_idle_after_eoi", {31'd0, f_req}, 32'd0);
        tick;
        chk("t1_rearb_req", {31'd0, f_req}, 32'd1);
        chk("t1_rearb_id", {27'd0, f_id}, 32'd5);
        picsr = 32'h0;
        ack_pulse;
        eoi(32'h5);

        // 2: withdraw before ack
        picsr = 32'h0000_0010;
        tick;
        chk("t2_req", {31'd0, f_req}, 32'd1);
        chk("t2_id", {27'd0, f_id}, 32'd4);
        picsr = 32'h0;
        tick;
        chk("t2_req_drop", {31'd0, f_req}, 32'd0);
        rd_on(16'h0003);
        chk("t2_idreg_idle", f_dat, 32'h0000_0004);
        tick;
        bus_off;
        chk("t2_stay_idle", {31'd0, f_req}, 32'd0);

        // 4: bad EOI, sticky error, clear on read, EOI in IDLE
        picsr = 32'h0000_0080;
        tick;
        chk("t4_id", {27'd0, f_id}, 32'd7);
        ack_pulse;
        picsr = 32'h0;
        eoi(32'h6);
        chk("t4_req", {31'd0, f_req}, 32'd0);
        rd_on(16'h0003);
        chk("t4_err_set", f_dat, 32'hC000_0007);
        tick;
        rd_on(16'h0003);
        chk("t4_err_clr", f_dat, 32'h8000_0007);
        tick;
        bus_off;
        eoi(32'h7);
        rd_on(16'h0003);
        chk("t4_good_eoi", f_dat, 32'h0000_0007);
        tick;
        bus_off;
        eoi(32'h0);
        rd_on(16'h0003);
        chk("t4_eoi_idle_err", f_dat, 32'h4000_0007);
        tick;
        bus_off;
        ack_pulse;
        rd_on(16'h0003);
        chk("t4_ack_idle_ignored", f_dat, 32'h0000_0007);
        tick;
        // ID register is read-only, EOI register is write-only, others decode to 0
        access = 1'b1; we = 1'b1; addr = 16'h0003; wdat = 32'h0000_0007;
        #1;
        chk("wr_idreg_dat", f_dat, 32'h0);
        tick;
        rd_on(16'h0004);
        chk("rd_eoireg_dat", f_dat, 32'h0);
        rd_on(16'h0005);
        chk("rd_other_dat", f_dat, 32'h0);
        rd_on(16'h0003);
        chk("wr_idreg_noeffect", f_dat, 32'h0000_0007);
        tick;
        bus_off;

        // 5: no preemption in REQ; ack beats simultaneous withdraw
        picsr = 32'h0000_0004;
        tick;
        chk("t5_id", {27'd0, f_id}, 32'd2);
        picsr = 32'h0000_0005;
        tick;
        chk("t5_nopreempt_id", {27'd0, f_id}, 32'd2);
        chk("t5_nopreempt_req", {31'd0, f_req}, 32'd1);
        ack = 1'b1;
        picsr = 32'h0000_0001;
        tick;
        ack = 1'b0;
        chk("t5_req", {31'd0, f_req}, 32'd0);
        rd_on(16'h0003);
        chk("t5_insvc", f_dat, 32'h8000_0002);
        tick;
        bus_off;
        picsr = 32'h0;
        eoi(32'h2);

        // 6: reset while in service
        picsr = 32'h0000_0008;
        tick;
        ack_pulse;
        rd_on(16'h0003);
        chk("t6_pre_insvc", f_dat, 32'h8000_0003);
        bus_off;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_req", {31'd0, f_req}, 32'd0);
        chk("t6_id", {27'd0, f_id}, 32'd0);
        rd_on(16'h0003);
        chk("t6_idreg", f_dat, 32'h0);
        bus_off;
        tick;
        chk("t6_req_back", {31'd0, f_req}, 32'd1);
        chk("t6_id_back", {27'd0, f_id}, 32'd3);

        // 3: round-robin service order 0, 1, 31, 0
        rst = 1'b1;
        picsr = 32'h0;
        tick;
        rst = 1'b0;
        picsr = 32'h8000_0003;
        tick;
        chk("t3_req0", {31'd0, r_req}, 32'd1);
        chk("t3_id0", {27'd0, r_id}, 32'd0);
        ack_pulse;
        eoi(32'h0);
        tick;
        chk("t3_id1", {27'd0, r_id}, 32'd1);
        ack_pulse;
        eoi(32'h1);
        tick;
        chk("t3_id31", {27'd0, r_id}, 32'd31);
        ack_pulse;
        rd_on(16'h0003);
        chk("t3_idreg_31", r_dat, 32'h8000_021F);
        bus_off;
        eoi(32'h1F);
        rd_on(16'h0003);
        chk("t3_rr_wrap", r_dat, 32'h0000_001F);
        tick;
        bus_off;
        chk("t3_req_again", {31'd0, r_req}, 32'd1);
        chk("t3_id_again", {27'd0, r_id}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
